issue_window: RTL and testbench

Parametrised, age-ordered instruction issue window sitting between the decoder and the execution units. Holds up to DEPTH decoded instructions, tracks readiness of two source operands by tag-match wakeup, issues the oldest ready instruction through a valid/accept handshake, compacts toward the head every cycle, and kills entries selectively by branch-context mask. Successor of the two-slot window: arbitrary depth, out-of-order issue within the window, and broadcast wakeup instead of polling a single head slot.

---
 rtl/issue_window_pkg.sv | 20 ++
 rtl/issue_window_pick_oldest.sv | 25 ++
 rtl/issue_window.sv | 174 +++++++++++++++++
 tb/tb_issue_window.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_window_pkg.sv
// Shared definitions for the issue window and its helpers: default widths,
// the zero-register tag, and the per-entry status flags.
package issue_window_pkg;

   localparam int DEPTH_DEF     = 4;
   localparam int W_PAYLOAD_DEF = 64;
   localparam int W_TAG_DEF     = 6;
   localparam int W_CTX_DEF     = 4;

   // Tag 0 is the architectural zero register: always available.
   localparam logic [W_TAG_DEF-1:0] TAG_ZERO = '0;

   // Status bits carried by every window entry.
   typedef struct packed {
      logic valid;
      logic rdy1;
      logic rdy2;
   } entry_flags_t;

endpackage

// File: rtl/issue_window_pick_oldest.sv
// Lowest-index priority picker: turns a ready vector into a one-hot grant
// on the oldest requester plus an any-request flag.
module issue_window_pick_oldest #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         any
);

   // seen[k] is set when some request exists below index k.
   logic [N:0] seen;

   assign seen[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pick
         assign seen[gi+1] = seen[gi] | req[gi];
         assign grant[gi]  = req[gi] & ~seen[gi];
      end
   endgenerate

   assign any = seen[N];

endmodule

// File: rtl/issue_window.sv
// Age-ordered issue window: holds decoded instructions oldest-first,
// wakes sources by broadcast tag match, issues the oldest ready entry,
// kills entries by branch-context mask and compacts toward index 0.
module issue_window
   import issue_window_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEF,
   parameter int W_PAYLOAD = W_PAYLOAD_DEF,
   parameter int W_TAG     = W_TAG_DEF,
   parameter int W_CTX     = W_CTX_DEF
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W_PAYLOAD-1:0]       in_payload,
   input  logic [W_TAG-1:0]           in_tag1,
   input  logic [W_TAG-1:0]           in_tag2,
   input  logic                       in_rdy1,
   input  logic                       in_rdy2,
   input  logic [W_CTX-1:0]           in_ctx,
   input  logic                       wake_valid,
   input  logic [W_TAG-1:0]           wake_tag,
   input  logic                       flush,
   input  logic [W_CTX-1:0]           flush_ctx,
   output logic                       issue_valid,
   input  logic                       issue_accept,
   output logic [W_PAYLOAD-1:0]       issue_payload,
   output logic [W_CTX-1:0]           issue_ctx,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [W_TAG-1:0] TAG_Z = W_TAG'(TAG_ZERO);

   entry_flags_t         flags_reg   [DEPTH];
   entry_flags_t         flags_next  [DEPTH];
   logic [W_PAYLOAD-1:0] payload_reg [DEPTH];
   logic [W_PAYLOAD-1:0] payload_next[DEPTH];
   logic [W_TAG-1:0]     tag1_reg    [DEPTH];
   logic [W_TAG-1:0]     tag1_next   [DEPTH];
   logic [W_TAG-1:0]     tag2_reg    [DEPTH];
   logic [W_TAG-1:0]     tag2_next   [DEPTH];
   logic [W_CTX-1:0]     ctx_reg     [DEPTH];
   logic [W_CTX-1:0]     ctx_next    [DEPTH];
   logic [CW-1:0]        count_reg;
   logic [CW-1:0]        count_next;
   logic [CW-1:0]        keep_pos;

   logic [DEPTH-1:0] kill;
   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] grant;
   logic [DEPTH-1:0] keep;
   logic [DEPTH-1:0] woken1;
   logic [DEPTH-1:0] woken2;
   logic             any_ready;

   logic in_kill;
   logic in_fire;
   logic in_rdy1_eff;
   logic in_rdy2_eff;

   // Per-entry kill, readiness, survival and wakeup terms.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign kill[gi]      = flush & (|(ctx_reg[gi] & flush_ctx));
         assign ready_vec[gi] = flags_reg[gi].valid & flags_reg[gi].rdy1
                              & flags_reg[gi].rdy2 & ~kill[gi];
         assign keep[gi]      = flags_reg[gi].valid & ~kill[gi]
                              & ~(grant[gi] & issue_accept);
         assign woken1[gi]    = flags_reg[gi].rdy1
                              | (wake_valid & (tag1_reg[gi] == wake_tag));
         assign woken2[gi]    = flags_reg[gi].rdy2
                              | (wake_valid & (tag2_reg[gi] == wake_tag));
      end
   endgenerate

   issue_window_pick_oldest #(
      .N (DEPTH)
   ) u_pick (
      .req   (ready_vec),
      .grant (grant),
      .any   (any_ready)
   );

   // Entries are contiguous from 0, so the last slot being valid means full.
   assign in_ready    = ~flags_reg[DEPTH-1].valid;
   assign issue_valid = any_ready;
   assign count       = count_reg;

   // Incoming instruction: dropped if the same-cycle flush hits its context.
   assign in_kill     = flush & (|(in_ctx & flush_ctx));
   assign in_fire     = in_valid & in_ready & ~in_kill;
   assign in_rdy1_eff = in_rdy1 | (in_tag1 == TAG_Z) | (wake_valid & (in_tag1 == wake_tag));
   assign in_rdy2_eff = in_rdy2 | (in_tag2 == TAG_Z) | (wake_valid & (in_tag2 == wake_tag));

   // One-hot grant mux; reads as zero when nothing is ready.
   always_comb begin
      issue_payload = '0;
      issue_ctx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            issue_payload = issue_payload | payload_reg[i];
            issue_ctx     = issue_ctx | ctx_reg[i];
         end
      end
   end

   // Compact survivors toward index 0 in age order, then append the newcomer.
   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         flags_next[j]   = '0;
         payload_next[j] = '0;
         tag1_next[j]    = '0;
         tag2_next[j]    = '0;
         ctx_next[j]     = '0;
      end
      keep_pos = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (keep[i]) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (keep_pos == j[CW-1:0]) begin
                  flags_next[j].valid = 1'b1;
                  flags_next[j].rdy1  = woken1[i];
                  flags_next[j].rdy2  = woken2[i];
                  payload_next[j]     = payload_reg[i];
                  tag1_next[j]        = tag1_reg[i];
                  tag2_next[j]        = tag2_reg[i];
                  ctx_next[j]         = ctx_reg[i];
               end
            end
            keep_pos = keep_pos + CW'(1);
         end
      end
      if (in_fire) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (keep_pos == j[CW-1:0]) begin
               flags_next[j].valid = 1'b1;
               flags_next[j].rdy1  = in_rdy1_eff;
               flags_next[j].rdy2  = in_rdy2_eff;
               payload_next[j]     = in_payload;
               tag1_next[j]        = in_tag1;
               tag2_next[j]        = in_tag2;
               ctx_next[j]         = in_ctx;
            end
         end
      end
      count_next = keep_pos + CW'(in_fire);
   end

   // Window state; reset empties the window immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int j = 0; j < DEPTH; j++) begin
            flags_reg[j]   <= '0;
            payload_reg[j] <= '0;
            tag1_reg[j]    <= '0;
            tag2_reg[j]    <= '0;
            ctx_reg[j]     <= '0;
         end
         count_reg <= '0;
      end else begin
         for (int j = 0; j < DEPTH; j++) begin
            flags_reg[j]   <= flags_next[j];
            payload_reg[j] <= payload_next[j];
            tag1_reg[j]    <= tag1_next[j];
            tag2_reg[j]    <= tag2_next[j];
            ctx_reg[j]     <= ctx_next[j];
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_issue_window.sv
// Directed bench for issue_window (DEPTH=4): basic issue, wakeup ordering,
// full-window refusal, context flush, tag-zero/same-cycle wakeup, async reset.
module tb_issue_window;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_payload;
   logic [5:0]  in_tag1;
   logic [5:0]  in_tag2;
   logic        in_rdy1;
   logic        in_rdy2;
   logic [3:0]  in_ctx;
   logic        wake_valid;
   logic [5:0]  wake_tag;
   logic        flush;
   logic [3:0]  flush_ctx;
   logic        issue_valid;
   logic        issue_accept;
   logic [63:0] issue_payload;
   logic [3:0]  issue_ctx;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   issue_window #(
      .DEPTH     (4),
      .W_PAYLOAD (64),
      .W_TAG     (6),
      .W_CTX     (4)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_payload    (in_payload),
      .in_tag1       (in_tag1),
      .in_tag2       (in_tag2),
      .in_rdy1       (in_rdy1),
      .in_rdy2       (in_rdy2),
      .in_ctx        (in_ctx),
      .wake_valid    (wake_valid),
      .wake_tag      (wake_tag),
      .flush         (flush),
      .flush_ctx     (flush_ctx),
      .issue_valid   (issue_valid),
      .issue_accept  (issue_accept),
      .issue_payload (issue_payload),
      .issue_ctx     (issue_ctx),
      .count         (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [63:0] p, input logic [5:0] t1, input logic [5:0] t2,
                         input logic r1, input logic r2, input logic [3:0] c);
      in_valid   = 1'b1;
      in_payload = p;
      in_tag1    = t1;
      in_tag2    = t2;
      in_rdy1    = r1;
      in_rdy2    = r2;
      in_ctx     = c;
   endtask

   task automatic idle();
      in_valid     = 1'b0;
      in_payload   = '0;
      in_tag1      = '0;
      in_tag2      = '0;
      in_rdy1      = 1'b0;
      in_rdy2      = 1'b0;
      in_ctx       = '0;
      wake_valid   = 1'b0;
      wake_tag     = '0;
      flush        = 1'b0;
      flush_ctx    = '0;
      issue_accept = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle();
      cycle();
      cycle();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
      checks++; if (issue_payload !== 64'h0) begin errors++; $display("FAIL reset_issue_payload: got %h expected 0", issue_payload); end
      checks++; if (issue_ctx !== 4'h0) begin errors++; $display("FAIL reset_issue_ctx: got %h expected 0", issue_ctx); end
      #2 rstn = 1'b1;
      cycle();
      $display("reset: count=%0d in_ready=%b issue_valid=%b", count, in_ready, issue_valid);
   endtask

   task automatic test_basic_issue();
      set_in(64'hA, 6'd1, 6'd2, 1'b1, 1'b1, 4'b0001);
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_no_same_cycle_issue: got %b expected 0", issue_valid); end
      cycle();
      idle();
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_issue_valid: got %b expected 1", issue_valid); end
      checks++; if (issue_payload !== 64'hA) begin errors++; $display("FAIL basic_payload: got %h expected a", issue_payload); end
      checks++; if (issue_ctx !== 4'b0001) begin errors++; $display("FAIL basic_ctx: got %b expected 0001", issue_ctx); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", count); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d expected 0", count); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b expected 0", issue_valid); end
      checks++; if (issue_payload !== 64'h0) begin errors++; $display("FAIL basic_idle_payload: got %h expected 0", issue_payload); end
      $display("basic: enqueue A, issue, accept -> count=%0d", count);
   endtask

   task automatic test_wakeup();
      set_in(64'hAA1, 6'd5, 6'd3, 1'b0, 1'b1, 4'b0001);
      cycle();
      set_in(64'hBB2, 6'd7, 6'd8, 1'b1, 1'b1, 4'b0001);
      cycle();
      idle();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL wake_count2: got %0d expected 2", count); end
      checks++; if (issue_payload !== 64'hBB2) begin errors++; $display("FAIL wake_b_first: got %h expected bb2", issue_payload); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_a_blocked: got %b expected 0", issue_valid); end
      wake_valid = 1'b1;
      wake_tag   = 6'd5;
      #1;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_no_same_cycle: got %b expected 0", issue_valid); end
      cycle();
      idle();
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL wake_a_valid: got %b expected 1", issue_valid); end
      checks++; if (issue_payload !== 64'hAA1) begin errors++; $display("FAIL wake_a_payload: got %h expected aa1", issue_payload); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL wake_drain: got %0d expected 0", count); end
      $display("wakeup: B issued before A, A issued after wake tag 5");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         set_in(64'h100 + 64'(k), 6'd1, 6'd1, 1'b1, 1'b1, 4'b0001);
         cycle();
      end
      idle();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
      set_in(64'h104, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0001);
      issue_accept = 1'b1;
      #1;
      checks++; if (issue_payload !== 64'h100) begin errors++; $display("FAIL full_head: got %h expected 100", issue_payload); end
      cycle();
      idle();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_refused_count: got %0d expected 3", count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_back: got %b expected 1", in_ready); end
      for (int k = 1; k < 4; k++) begin
         checks++; if (issue_payload !== 64'h100 + 64'(k)) begin errors++; $display("FAIL full_drain_%0d: got %h expected %h", k, issue_payload, 64'h100 + 64'(k)); end
         issue_accept = 1'b1;
         cycle();
         issue_accept = 1'b0;
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", count); end
      $display("back_to_back: full window refused input while issuing, drained in order");
   endtask

   task automatic test_flush();
      set_in(64'hC0, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0001); cycle();
      set_in(64'hC1, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0010); cycle();
      set_in(64'hC2, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0001); cycle();
      set_in(64'hC3, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0100); cycle();
      idle();
      flush     = 1'b1;
      flush_ctx = 4'b0001;
      #1;
      checks++; if (issue_payload !== 64'hC1) begin errors++; $display("FAIL flush_mask_head: got %h expected c1", issue_payload); end
      cycle();
      idle();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_count: got %0d expected 2", count); end
      checks++; if (issue_ctx !== 4'b0010) begin errors++; $display("FAIL flush_order0: got %b expected 0010", issue_ctx); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      checks++; if (issue_ctx !== 4'b0100) begin errors++; $display("FAIL flush_order1: got %b expected 0100", issue_ctx); end
      checks++; if (issue_payload !== 64'hC3) begin errors++; $display("FAIL flush_order1_payload: got %h expected c3", issue_payload); end
      // Incoming instruction in a flushed context is dropped.
      set_in(64'hD1, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0001);
      flush     = 1'b1;
      flush_ctx = 4'b0001;
      cycle();
      idle();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_incoming_drop: got %0d expected 1", count); end
      // Incoming instruction in a surviving context is kept.
      set_in(64'hD2, 6'd1, 6'd1, 1'b1, 1'b1, 4'b0010);
      flush     = 1'b1;
      flush_ctx = 4'b0001;
      cycle();
      idle();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_incoming_keep: got %0d expected 2", count); end
      // Flush with an empty mask does nothing.
      flush     = 1'b1;
      flush_ctx = 4'b0000;
      #1;
      checks++; if (issue_payload !== 64'hC3) begin errors++; $display("FAIL flush_zero_mask_issue: got %h expected c3", issue_payload); end
      cycle();
      idle();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_zero_mask_count: got %0d expected 2", count); end
      issue_accept = 1'b1;
      cycle();
      checks++; if (issue_payload !== 64'hD2) begin errors++; $display("FAIL flush_last: got %h expected d2", issue_payload); end
      cycle();
      issue_accept = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_empty: got %0d expected 0", count); end
      $display("flush: ctx 0001 killed, order 0010 then 0100 kept");
   endtask

   task automatic test_tag_zero();
      set_in(64'hE0, 6'd0, 6'd7, 1'b0, 1'b1, 4'b0001);
      cycle();
      idle();
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL tag0_ready: got %b expected 1", issue_valid); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      set_in(64'hF0, 6'd3, 6'd12, 1'b1, 1'b0, 4'b0001);
      wake_valid = 1'b1;
      wake_tag   = 6'd12;
      cycle();
      idle();
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL enq_wake_ready: got %b expected 1", issue_valid); end
      checks++; if (issue_payload !== 64'hF0) begin errors++; $display("FAIL enq_wake_payload: got %h expected f0", issue_payload); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      set_in(64'hF1, 6'd3, 6'd13, 1'b1, 1'b0, 4'b0001);
      cycle();
      idle();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL not_ready_held: got %b expected 0", issue_valid); end
      wake_valid = 1'b1;
      wake_tag   = 6'd13;
      cycle();
      idle();
      checks++; if (issue_payload !== 64'hF1) begin errors++; $display("FAIL stored_wake: got %h expected f1", issue_payload); end
      issue_accept = 1'b1;
      cycle();
      issue_accept = 1'b0;
      $display("tag_zero: tag0 ready at enqueue, same-cycle wake captured");
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(64'h200 + 64'(k), 6'd1, 6'd1, 1'b1, 1'b1, 4'b0010);
         cycle();
      end
      idle();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre_count: got %0d expected 3", count); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL areset_issue_valid: got %b expected 0", issue_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
      checks++; if (issue_payload !== 64'h0) begin errors++; $display("FAIL areset_payload: got %h expected 0", issue_payload); end
      cycle();
      #2 rstn = 1'b1;
      cycle();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_after: got %0d expected 0", count); end
      $display("async_reset: window cleared between clock edges");
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_wakeup();
      test_back_to_back();
      test_flush();
      test_tag_zero();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
